// File: rtl/wb_pkg.sv
// Shared types and defaults for the writeback arbiter: requester ids and the
// request record used to mux the winning requester into the output register.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_id_e;

  typedef struct packed {
    logic                 valid;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  function automatic wb_id_e wb_other(wb_id_e id);
    return (id == WB_ALU) ? WB_LSU : WB_ALU;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: two requester channels, the register-file write port and the
// read-port bypass signals seen by the arbiter.
interface wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);

    logic              alu_valid_i;
    logic [ADDR_W-1:0] alu_addr_i;
    logic [DATA_W-1:0] alu_data_i;
    logic              alu_ready_o;

    logic              lsu_valid_i;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [DATA_W-1:0] lsu_data_i;
    logic              lsu_ready_o;

    logic              flush_i;

    logic              rd_wren_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_o;

    logic [ADDR_W-1:0] rs1_addr_i;
    logic [ADDR_W-1:0] rs2_addr_i;
    logic [DATA_W-1:0] rf_rs1_data_i;
    logic [DATA_W-1:0] rf_rs2_data_i;
    logic [DATA_W-1:0] rs1_data_o;
    logic [DATA_W-1:0] rs2_data_o;

    // Requester / pipeline side.
    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        input  alu_ready_o,
        output lsu_valid_i, lsu_addr_i, lsu_data_i,
        input  lsu_ready_o,
        output flush_i,
        input  rd_wren_o, rd_addr_o, rd_data_o,
        output rs1_addr_i, rs2_addr_i, rf_rs1_data_i, rf_rs2_data_i,
        input  rs1_data_o, rs2_data_o
    );

    // Arbiter side.
    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        output alu_ready_o,
        input  lsu_valid_i, lsu_addr_i, lsu_data_i,
        output lsu_ready_o,
        input  flush_i,
        output rd_wren_o, rd_addr_o, rd_data_o,
        input  rs1_addr_i, rs2_addr_i, rf_rs1_data_i, rf_rs2_data_i,
        output rs1_data_o, rs2_data_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer remembers the last winner; on a tie
// the other requester wins. Every grant is a transfer, so the pointer follows it.
module rr_arb2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    wb_id_e last_q, last_d;
    wb_id_e winner;

    always_comb begin
        gnt    = 2'b00;
        winner = wb_other(last_q);
        if (en) begin
            if (req == 2'b11) begin
                gnt = (winner == WB_LSU) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt[1]) begin
            last_d = WB_LSU;
        end else if (gnt[0]) begin
            last_d = WB_ALU;
        end
    end

    // Reset value ALU as last winner, so the first tie goes to the LSU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= WB_ALU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin between ALU and LSU, one registered
// register-file write per cycle, and read-port bypass from that write.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W = WB_DATA_W,
    parameter int unsigned ADDR_W = WB_ADDR_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    wb_arbiter_if.slave  bus
);

    wb_req_t alu_req, lsu_req, sel_req;
    logic [1:0] gnt;
    logic       arb_en;
    logic       wr_fire;

    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    assign alu_req = '{valid: bus.alu_valid_i, addr: bus.alu_addr_i, data: bus.alu_data_i};
    assign lsu_req = '{valid: bus.lsu_valid_i, addr: bus.lsu_addr_i, data: bus.lsu_data_i};

    // Holding off grants during flush or reset keeps requesters waiting instead
    // of losing their write.
    assign arb_en = ~bus.flush_i & ~rst_i;

    rr_arb2 u_rr_arb2 (
        .clk (clk_i),
        .rst (rst_i),
        .req ({lsu_req.valid, alu_req.valid}),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign bus.alu_ready_o = gnt[0];
    assign bus.lsu_ready_o = gnt[1];

    always_comb begin
        sel_req = '0;
        unique case (gnt)
            2'b01:   sel_req = alu_req;
            2'b10:   sel_req = lsu_req;
            default: sel_req = '0;
        endcase
    end

    // Writes to x0 are accepted but dropped here.
    assign wr_fire = sel_req.valid & (sel_req.addr != '0);

    always_comb begin
        wren_d = wr_fire;
        addr_d = addr_q;
        data_d = data_q;
        if (wr_fire) begin
            addr_d = sel_req.addr;
            data_d = sel_req.data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wren_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wren_q <= wren_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign bus.rd_wren_o = wren_q;
    assign bus.rd_addr_o = addr_q;
    assign bus.rd_data_o = data_q;

    always_comb begin
        bus.rs1_data_o = bus.rf_rs1_data_i;
        bus.rs2_data_o = bus.rf_rs2_data_i;
        if (wren_q && (addr_q == bus.rs1_addr_i) && (bus.rs1_addr_i != '0)) begin
            bus.rs1_data_o = data_q;
        end
        if (wren_q && (addr_q == bus.rs2_addr_i) && (bus.rs2_addr_i != '0)) begin
            bus.rs2_data_o = data_q;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, grants, round-robin order, x0 writes,
// flush, bypass and asynchronous reset cancelling a pending write.
module tb_wb_arbiter;

    logic clk_i;
    logic rst_i;
    int   n_tests;
    int   n_fail;

    wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    wb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [4:0] exp_addr [4];
        logic [1:0] exp_gnt  [4];
        exp_addr = '{5'd2, 5'd1, 5'd2, 5'd1};
        exp_gnt  = '{2'b10, 2'b01, 2'b10, 2'b01};
        n_tests = 0;
        n_fail  = 0;

        rst_i = 1'b1;
        bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd1; bus.alu_data_i = 32'h0;
        bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd2; bus.lsu_data_i = 32'h0;
        bus.flush_i = 1'b0;
        bus.rs1_addr_i = 5'd0; bus.rs2_addr_i = 5'd0;
        bus.rf_rs1_data_i = 32'h0; bus.rf_rs2_data_i = 32'h0;
        #3;
        check_eq("rst_wren", {31'd0, bus.rd_wren_o}, 32'd0);
        check_eq("rst_addr", {27'd0, bus.rd_addr_o}, 32'd0);
        check_eq("rst_data", bus.rd_data_o, 32'd0);
        check_eq("rst_readys", {30'd0, bus.lsu_ready_o, bus.alu_ready_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bus.alu_valid_i = 1'b0;
        bus.lsu_valid_i = 1'b0;

        // Single ALU request
        bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd5; bus.alu_data_i = 32'hDEADBEEF;
        #1;
        check_eq("alu_single_ready", {30'd0, bus.lsu_ready_o, bus.alu_ready_o}, 32'd1);
        step();
        bus.alu_valid_i = 1'b0;
        check_eq("alu_single_wren", {31'd0, bus.rd_wren_o}, 32'd1);
        check_eq("alu_single_addr", {27'd0, bus.rd_addr_o}, 32'd5);
        check_eq("alu_single_data", bus.rd_data_o, 32'hDEADBEEF);

        // Round robin with both valid
        bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd1; bus.alu_data_i = 32'h11;
        bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd2; bus.lsu_data_i = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("rr_gnt%0d", i), {30'd0, bus.lsu_ready_o, bus.alu_ready_o},
                     {30'd0, exp_gnt[i]});
            step();
            check_eq($sformatf("rr_addr%0d", i), {27'd0, bus.rd_addr_o}, {27'd0, exp_addr[i]});
            check_eq($sformatf("rr_wren%0d", i), {31'd0, bus.rd_wren_o}, 32'd1);
        end
        bus.alu_valid_i = 1'b0;
        bus.lsu_valid_i = 1'b0;
        #1;
        check_eq("idle_readys", {30'd0, bus.lsu_ready_o, bus.alu_ready_o}, 32'd0);
        step();
        check_eq("idle_wren", {31'd0, bus.rd_wren_o}, 32'd0);
        check_eq("idle_hold_addr", {27'd0, bus.rd_addr_o}, 32'd1);
        check_eq("idle_hold_data", bus.rd_data_o, 32'h11);

        // LSU write to x0: accepted, never written
        bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd0; bus.lsu_data_i = 32'h1234;
        #1;
        check_eq("x0_ready", {30'd0, bus.lsu_ready_o, bus.alu_ready_o}, 32'd2);
        step();
        bus.lsu_valid_i = 1'b0;
        check_eq("x0_wren", {31'd0, bus.rd_wren_o}, 32'd0);
        check_eq("x0_hold_data", bus.rd_data_o, 32'h11);

        // Flush holds off the ALU, which transfers once flush drops
        bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd7; bus.alu_data_i = 32'h77;
        bus.flush_i = 1'b1;
        #1;
        check_eq("flush_ready", {30'd0, bus.lsu_ready_o, bus.alu_ready_o}, 32'd0);
        step();
        check_eq("flush_wren", {31'd0, bus.rd_wren_o}, 32'd0);
        bus.flush_i = 1'b0;
        #1;
        check_eq("postflush_ready", {30'd0, bus.lsu_ready_o, bus.alu_ready_o}, 32'd1);
        step();
        bus.alu_valid_i = 1'b0;
        check_eq("postflush_wren", {31'd0, bus.rd_wren_o}, 32'd1);
        check_eq("postflush_addr", {27'd0, bus.rd_addr_o}, 32'd7);
        check_eq("postflush_data", bus.rd_data_o, 32'h77);

        // Bypass
        bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd3; bus.alu_data_i = 32'hA5A5A5A5;
        step();
        bus.alu_valid_i = 1'b0;
        bus.rs1_addr_i = 5'd3; bus.rs2_addr_i = 5'd4;
        bus.rf_rs1_data_i = 32'h0; bus.rf_rs2_data_i = 32'h0;
        #1;
        check_eq("byp_rs1_hit", bus.rs1_data_o, 32'hA5A5A5A5);
        check_eq("byp_rs2_miss", bus.rs2_data_o, 32'h0);
        bus.rs2_addr_i = 5'd3; bus.rf_rs2_data_i = 32'h55;
        bus.rs1_addr_i = 5'd0; bus.rf_rs1_data_i = 32'h66;
        #1;
        check_eq("byp_rs2_hit", bus.rs2_data_o, 32'hA5A5A5A5);
        check_eq("byp_rs1_x0", bus.rs1_data_o, 32'h66);
        step();
        bus.rs1_addr_i = 5'd3;
        #1;
        check_eq("byp_nowren", bus.rs1_data_o, 32'h66);

        // Async reset cancels a pending write; pointer returns to favour LSU
        bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd9; bus.lsu_data_i = 32'h99;
        #1;
        check_eq("pre_rst_ready", {30'd0, bus.lsu_ready_o, bus.alu_ready_o}, 32'd2);
        step();
        bus.lsu_valid_i = 1'b0;
        check_eq("pre_rst_wren", {31'd0, bus.rd_wren_o}, 32'd1);
        #2;
        rst_i = 1'b1;
        #1;
        check_eq("async_rst_wren", {31'd0, bus.rd_wren_o}, 32'd0);
        check_eq("async_rst_addr", {27'd0, bus.rd_addr_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd1; bus.alu_data_i = 32'h11;
        bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd2; bus.lsu_data_i = 32'h22;
        #1;
        check_eq("post_rst_gnt", {30'd0, bus.lsu_ready_o, bus.alu_ready_o}, 32'd2);
        step();
        bus.alu_valid_i = 1'b0;
        bus.lsu_valid_i = 1'b0;
        check_eq("post_rst_wren", {31'd0, bus.rd_wren_o}, 32'd1);
        check_eq("post_rst_addr", {27'd0, bus.rd_addr_o}, 32'd2);
        check_eq("post_rst_data", bus.rd_data_o, 32'h22);
        step();
        check_eq("post_rst_idle", {31'd0, bus.rd_wren_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
